// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared sizing for the dpram-backed streaming FIFO controller.
// CAP is the total word capacity: the full RAM plus the two skid entries.
package dpram_fifo_ctrl_pkg;
   localparam int unsigned AWIDTH_DEF    = 12;
   localparam int unsigned DWIDTH_DEF    = 40;
   localparam int unsigned NUM_WORDS_DEF = 4096;
   localparam int unsigned CAP           = NUM_WORDS_DEF + 2;
endpackage

// File: rtl/dpram_fifo_skid.sv
// Two-entry FIFO-ordered output buffer that holds words returned by RAM port B.
// The head entry drives the consumer directly.
module dpram_fifo_skid
   import dpram_fifo_ctrl_pkg::*;
#(
   parameter int unsigned DWIDTH = DWIDTH_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic [DWIDTH-1:0] i_load_data,
   input  logic              i_pop,
   output logic [DWIDTH-1:0] o_head_data,
   output logic [1:0]        o_skid_cnt
);

   logic [DWIDTH-1:0] r_d0;
   logic [DWIDTH-1:0] r_d1;
   logic [1:0]        r_cnt;

   // A load arriving with a pop lands behind whatever entry survives the pop
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_d0  <= '0;
         r_d1  <= '0;
         r_cnt <= 2'd0;
      end else if (i_clear) begin
         r_d0  <= '0;
         r_d1  <= '0;
         r_cnt <= 2'd0;
      end else begin
         case ({i_load, i_pop})
            2'b10: begin
               if (r_cnt == 2'd0) r_d0 <= i_load_data;
               else               r_d1 <= i_load_data;
               r_cnt <= r_cnt + 2'd1;
            end
            2'b01: begin
               r_d0  <= r_d1;
               r_cnt <= r_cnt - 2'd1;
            end
            2'b11: begin
               if (r_cnt == 2'd2) begin
                  r_d0 <= r_d1;
                  r_d1 <= i_load_data;
               end else begin
                  r_d0 <= i_load_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_head_data = r_d0;
   assign o_skid_cnt  = r_cnt;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around a 1-cycle-latency dual-port RAM.
// Port A writes, port B reads; returned words land in a 2-entry skid buffer.
module dpram_fifo_ctrl
   import dpram_fifo_ctrl_pkg::*;
#(
   parameter int unsigned AWIDTH    = AWIDTH_DEF,
   parameter int unsigned NUM_WORDS = NUM_WORDS_DEF,
   parameter int unsigned DWIDTH    = DWIDTH_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DWIDTH-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_data,
   output logic [AWIDTH:0]   count,
   output logic [AWIDTH-1:0] ram_address_a,
   output logic              ram_wren_a,
   output logic [DWIDTH-1:0] ram_data_a,
   output logic [AWIDTH-1:0] ram_address_b,
   output logic              ram_wren_b,
   output logic [DWIDTH-1:0] ram_data_b,
   input  logic [DWIDTH-1:0] ram_out_b
);

   localparam int unsigned PW = AWIDTH + 1;

   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [PW-1:0]     r_count;
   logic              r_inflight;
   logic [AWIDTH-1:0] r_addr_b;

   logic [PW-1:0]     w_used;
   logic [1:0]        w_skid_cnt;
   logic [2:0]        w_occ;
   logic              w_push;
   logic              w_pop;
   logic              w_issue;

   assign w_used   = r_wr_ptr - r_rd_ptr;
   assign in_ready = resetn & ~flush & (w_used != PW'(NUM_WORDS));
   assign w_push   = in_valid & in_ready;
   assign w_pop    = out_valid & out_ready & ~flush;

   // Skid slots that will be taken after this edge; a same-cycle pop frees one
   assign w_occ   = 3'(w_skid_cnt) + 3'(r_inflight) - 3'(w_pop);
   assign w_issue = ~flush & (w_used != '0) & (w_occ < 3'd2);

   assign ram_address_a = r_wr_ptr[AWIDTH-1:0];
   assign ram_wren_a    = w_push;
   assign ram_data_a    = in_data;
   assign ram_address_b = w_issue ? r_rd_ptr[AWIDTH-1:0] : r_addr_b;
   assign ram_wren_b    = 1'b0;
   assign ram_data_b    = '0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_inflight <= 1'b0;
         r_addr_b   <= '0;
      end else if (flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_inflight <= 1'b0;
         r_addr_b   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
            r_addr_b <= r_rd_ptr[AWIDTH-1:0];
         end
         r_inflight <= w_issue;
         // Words only enter on push and leave on pop; internal moves keep the total
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + PW'(1);
            2'b01:   r_count <= r_count - PW'(1);
            default: ;
         endcase
      end
   end

   dpram_fifo_skid #(
      .DWIDTH(DWIDTH)
   ) u_skid (
      .clk        (clk),
      .resetn     (resetn),
      .i_clear    (flush),
      .i_load     (r_inflight),
      .i_load_data(ram_out_b),
      .i_pop      (w_pop),
      .o_head_data(out_data),
      .o_skid_cnt (w_skid_cnt)
   );

   assign out_valid = (w_skid_cnt != 2'd0);
   assign count     = r_count;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: a behavioural 4096x40 RAM, a vector table for the
// early cycle-by-cycle behaviour, directed corner sequences and an order scoreboard.
module tb_dpram_fifo_ctrl;
   import dpram_fifo_ctrl_pkg::*;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 40;
   localparam int unsigned NW = 4096;

   logic          clk;
   logic          resetn;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [AW:0]   count;
   logic [AW-1:0] ram_address_a;
   logic          ram_wren_a;
   logic [DW-1:0] ram_data_a;
   logic [AW-1:0] ram_address_b;
   logic          ram_wren_b;
   logic [DW-1:0] ram_data_b;
   logic [DW-1:0] ram_out_b;

   dpram_fifo_ctrl dut (
      .clk          (clk),
      .resetn       (resetn),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .count        (count),
      .ram_address_a(ram_address_a),
      .ram_wren_a   (ram_wren_a),
      .ram_data_a   (ram_data_a),
      .ram_address_b(ram_address_b),
      .ram_wren_b   (ram_wren_b),
      .ram_data_b   (ram_data_b),
      .ram_out_b    (ram_out_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-output dual-port RAM model
   logic [DW-1:0] mem [NW];
   always @(posedge clk) begin
      if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
      ram_out_b <= mem[ram_address_b];
   end

   int n_checks = 0;
   int n_fail   = 0;
   int n_pop    = 0;
   logic [DW-1:0] sb_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: every accepted word must come out once, in order
   always @(negedge clk) begin
      if (!resetn || flush) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) chk("sb_underflow", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
            else                  chk("sb_order", 64'(out_data), 64'(sb_q.pop_front()));
            n_pop++;
         end
         if (in_valid && in_ready) sb_q.push_back(in_data);
      end
   end

   typedef struct {
      logic          iv;
      logic [DW-1:0] d;
      logic          ordy;
      logic          fl;
      logic          ov;
      logic          chkd;
      logic [DW-1:0] od;
      logic [AW:0]   cnt;
      logic          ir;
   } vec_t;

   vec_t vecs[11];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ov(input string nm);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      chk(nm, 64'(out_valid), 64'd1);
   endtask

   task automatic drain(input string nm);
      int n;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (count != '0 && n < 6000) begin
         step();
         n++;
      end
      out_ready = 1'b0;
      chk(nm, 64'(count), 64'd0);
   endtask

   task automatic push_n(input int n, input int base);
      out_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(base + i);
         step();
      end
      in_valid = 1'b0;
      repeat (4) step();
   endtask

   int acc;
   int edges;
   int pushed;
   int start_pop;
   int cyc;

   initial begin
      //            iv  d        or fl   ov chkd od       cnt     ir
      vecs[0]  = '{1'b1, 40'hA1, 1'b0, 1'b0, 1'b0, 1'b1, 40'h0,  13'd0, 1'b1};
      vecs[1]  = '{1'b1, 40'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 40'h0,  13'd1, 1'b1};
      vecs[2]  = '{1'b0, 40'h0,  1'b0, 1'b0, 1'b0, 1'b1, 40'h0,  13'd2, 1'b1};
      vecs[3]  = '{1'b0, 40'h0,  1'b0, 1'b0, 1'b1, 1'b1, 40'hA1, 13'd2, 1'b1};
      vecs[4]  = '{1'b0, 40'h0,  1'b1, 1'b0, 1'b1, 1'b1, 40'hA1, 13'd2, 1'b1};
      vecs[5]  = '{1'b1, 40'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 40'hA2, 13'd1, 1'b1};
      vecs[6]  = '{1'b0, 40'h0,  1'b1, 1'b0, 1'b0, 1'b0, 40'h0,  13'd1, 1'b1};
      vecs[7]  = '{1'b0, 40'h0,  1'b1, 1'b0, 1'b0, 1'b0, 40'h0,  13'd1, 1'b1};
      vecs[8]  = '{1'b0, 40'h0,  1'b0, 1'b0, 1'b1, 1'b1, 40'hA3, 13'd1, 1'b1};
      vecs[9]  = '{1'b1, 40'hA4, 1'b1, 1'b1, 1'b1, 1'b1, 40'hA3, 13'd1, 1'b0};
      vecs[10] = '{1'b0, 40'h0,  1'b0, 1'b0, 1'b0, 1'b1, 40'h0,  13'd0, 1'b1};

      resetn = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 40'h55; out_ready = 1'b0;
      repeat (2) step();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_wren_a", 64'(ram_wren_a), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("wren_b_tied", 64'(ram_wren_b), 64'd0);
      chk("data_b_tied", 64'(ram_data_b), 64'd0);
      resetn = 1'b1;

      // Cycle-accurate table starting from the freshly released empty state
      for (int i = 0; i < 11; i++) begin
         in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy; flush = vecs[i].fl;
         @(negedge clk);
         chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
         chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].cnt));
         chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].ir));
         if (vecs[i].chkd) chk($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].od));
         step();
      end
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

      // Single word: out_valid three edges after the accepting edge
      in_valid = 1'b1; in_data = 40'h12_3456_789A;
      step();
      in_valid = 1'b0;
      edges = 1;
      while (!out_valid && edges < 10) begin
         step();
         edges++;
      end
      chk("single_latency", 64'(edges), 64'd3);
      chk("single_data", 64'(out_data), 64'h12_3456_789A);
      chk("single_count", 64'(count), 64'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("single_count_after_pop", 64'(count), 64'd0);
      chk("single_empty", 64'(out_valid), 64'd0);

      // Fill to capacity with the consumer stalled
      acc = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         in_valid = 1'b1; in_data = DW'(i);
         @(negedge clk);
         if (!in_ready) break;
         acc++;
         step();
      end
      chk("fill_accepts", 64'(acc), 64'(CAP));
      chk("fill_count", 64'(count), 64'd4098);
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      chk("fill_head", 64'(out_data), 64'd0);
      step();
      out_ready = 1'b0;
      chk("fill_ready_after_pop", 64'(in_ready), 64'd1);
      chk("fill_count_after_pop", 64'(count), 64'd4097);
      drain("fill_drain");

      // Steady state: ten words held, push and pop every cycle
      push_n(10, 32'h1000);
      chk("steady_start_count", 64'(count), 64'd10);
      for (int k = 0; k < 50; k++) begin
         in_valid = 1'b1; out_ready = 1'b1; in_data = DW'(32'h2000 + k);
         @(negedge clk);
         chk("steady_out_valid", 64'(out_valid), 64'd1);
         chk("steady_in_ready", 64'(in_ready), 64'd1);
         chk("steady_count", 64'(count), 64'd10);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("steady_end_count", 64'(count), 64'd10);
      drain("steady_drain");

      // Flush with a push in the same cycle: the pushed word must vanish
      push_n(5, 32'h3000);
      flush = 1'b1; in_valid = 1'b1; in_data = 40'hDEAD; out_ready = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      in_valid = 1'b1; in_data = 40'h77;
      step();
      in_valid = 1'b0;
      wait_ov("flush_next_valid");
      chk("flush_next_data", 64'(out_data), 64'h77);
      drain("flush_drain");

      // Wrap: 10000 words with random throttling on both sides
      pushed = 0;
      start_pop = n_pop;
      cyc = 0;
      while ((n_pop - start_pop) < 10000 && cyc < 40000) begin
         in_valid  = (pushed < 10000) && ($urandom_range(3) != 0);
         in_data   = DW'(pushed);
         out_ready = ($urandom_range(3) != 0);
         @(negedge clk);
         if (in_valid && in_ready) pushed++;
         step();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("wrap_pops", 64'(n_pop - start_pop), 64'd10000);
      chk("wrap_sb_empty", 64'(sb_q.size()), 64'd0);
      chk("wrap_count", 64'(count), 64'd0);

      // Asynchronous reset mid-cycle with a read in flight
      push_n(100, 32'h5000);
      out_ready = 1'b1;
      step();
      #2;
      out_ready = 1'b0;
      resetn = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd0);
      step();
      resetn = 1'b1;
      in_valid = 1'b1; in_data = 40'hAB;
      step();
      in_valid = 1'b0;
      wait_ov("arst_next_valid");
      chk("arst_first_data", 64'(out_data), 64'hAB);
      chk("arst_count_one", 64'(count), 64'd1);
      drain("arst_drain");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
